// File: rtl/vga_sync_receiver.sv
// Rebuilds the pixel position from incoming hsync/vsync. Checks line and frame periods
// against the configured mode, and reports lock status and timing errors.
module vga_sync_receiver #(
  parameter int H_TOTAL     = 1056,
  parameter int V_TOTAL     = 628,
  parameter int HSYNC_START = 840,
  parameter int VSYNC_START = 601,
  parameter int LOCK_FRAMES = 2,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync,
  input  logic             vsync,
  output logic [CNT_W-1:0] rx_hcount,
  output logic [CNT_W-1:0] rx_vcount,
  output logic             locked,
  output logic             frame_start,
  output logic             h_err,
  output logic             v_err,
  output logic [7:0]       err_count
);

  // state  | meaning
  // SEARCH | waiting for a vsync edge to start checking
  // VERIFY | counting clean frames toward lock
  // LOCKED | timing verified, position outputs trustworthy
  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  // The period counter must reach 2*H_TOTAL, which can exceed the position width.
  localparam int P_W = $clog2(2 * H_TOTAL + 1);
  localparam int G_W = $clog2(LOCK_FRAMES + 1);

  localparam logic [P_W-1:0]   H_PERIOD = P_W'(H_TOTAL);
  localparam logic [P_W-1:0]   P_MAX    = P_W'(2 * H_TOTAL);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_LOAD   = CNT_W'(HSYNC_START);
  localparam logic [CNT_W-1:0] V_LOAD   = CNT_W'(VSYNC_START);
  localparam logic [CNT_W-1:0] V_FRAME  = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] V_SAT    = {CNT_W{1'b1}};
  localparam logic [G_W-1:0]   G_LAST   = G_W'(LOCK_FRAMES - 1);

  logic             hsync_q;
  logic             vsync_q;
  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [G_W-1:0]   good_frames;
  logic [G_W-1:0]   good_n;
  logic [P_W-1:0]   h_period;
  logic [CNT_W-1:0] v_lines;
  logic             h_seen;

  logic       hs_rise;
  logic       vs_rise;
  logic       h_wrap;
  logic       checking;
  logic       bad_line;
  logic       bad_frame;
  logic [8:0] err_sum;
  logic [7:0] err_next;

  assign hs_rise  = hsync & ~hsync_q;
  assign vs_rise  = vsync & ~vsync_q;
  assign h_wrap   = ~hs_rise & (rx_hcount >= H_LAST);
  assign checking = (state != SEARCH);

  // A missing hsync is flagged once, in the cycle the period counter hits its ceiling.
  assign bad_line  = checking & ((hs_rise & h_seen & (h_period != H_PERIOD)) |
                                 (~hs_rise & (h_period == P_MAX - P_W'(1))));
  assign bad_frame = checking & vs_rise & (v_lines != V_FRAME);

  assign err_sum  = {1'b0, err_count} + {8'd0, bad_line} + {8'd0, bad_frame};
  assign err_next = err_sum[8] ? 8'hff : err_sum[7:0];

  assign frame_start = locked && (rx_hcount == '0) && (rx_vcount == '0);

  always_comb begin
    state_n = state;
    good_n  = good_frames;
    case (state)
      SEARCH: begin
        if (vs_rise) begin
          state_n = VERIFY;
          good_n  = '0;
        end
      end
      VERIFY: begin
        if (bad_line || bad_frame) begin
          state_n = SEARCH;
        end else if (vs_rise) begin
          good_n = good_frames + G_W'(1);
          if (good_frames == G_LAST) state_n = LOCKED;
        end
      end
      LOCKED: begin
        if (bad_line || bad_frame) state_n = SEARCH;
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      state       <= SEARCH;
      good_frames <= '0;
      h_period    <= '0;
      v_lines     <= '0;
      h_seen      <= 1'b0;
      rx_hcount   <= '0;
      rx_vcount   <= '0;
      locked      <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      err_count   <= '0;
    end else begin
      hsync_q     <= hsync;
      vsync_q     <= vsync;
      state       <= state_n;
      good_frames <= good_n;
      locked      <= (state == LOCKED);
      h_err       <= bad_line;
      v_err       <= bad_frame;
      err_count   <= err_next;

      if (hs_rise)     rx_hcount <= H_LOAD;
      else if (h_wrap) rx_hcount <= '0;
      else             rx_hcount <= rx_hcount + CNT_W'(1);

      if (vs_rise)     rx_vcount <= V_LOAD;
      else if (h_wrap) rx_vcount <= (rx_vcount >= V_LAST) ? '0 : rx_vcount + CNT_W'(1);

      if (hs_rise)               h_period <= P_W'(1);
      else if (h_period != P_MAX) h_period <= h_period + P_W'(1);

      if (vs_rise)                    v_lines <= '0;
      else if (hs_rise && v_lines != V_SAT) v_lines <= v_lines + CNT_W'(1);

      // Re-entering SEARCH discards the line reference, so the next hsync only re-arms.
      if (state_n == SEARCH && state != SEARCH) h_seen <= 1'b0;
      else if (hs_rise)                         h_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a reduced video mode (40x10) so whole frames run quickly.
// A behavioural sync source can stretch a line, drop a line or mask hsync on demand.
module tb_vga_sync_receiver;
  localparam int H_T = 40;
  localparam int V_T = 10;
  localparam int HS  = 32;
  localparam int VS  = 7;
  localparam int LF  = 2;
  localparam int CW  = 11;
  localparam int FRAME = H_T * V_T;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hsync = 1'b0;
  logic          vsync = 1'b0;
  logic [CW-1:0] rx_hcount;
  logic [CW-1:0] rx_vcount;
  logic          locked;
  logic          frame_start;
  logic          h_err;
  logic          v_err;
  logic [7:0]    err_count;

  vga_sync_receiver #(
    .H_TOTAL(H_T), .V_TOTAL(V_T), .HSYNC_START(HS), .VSYNC_START(VS),
    .LOCK_FRAMES(LF), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .rx_hcount(rx_hcount), .rx_vcount(rx_vcount), .locked(locked),
    .frame_start(frame_start), .h_err(h_err), .v_err(v_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int s_h = 0, s_v = 0, line_len = H_T, frame_len = V_T, hs_block = 0;
  logic hs_prev = 1'b0, vs_prev = 1'b0, locked_prev = 1'b0;

  int n_herr, n_verr, n_fs, fs_bad, trk_bad, first_herr, first_verr;
  int lock_rise, lock_fall, last_fs, n_vs, samp_v;
  int vs_cyc[8];
  logic samp_hs_rise = 1'b0;
  bit track_en = 1'b0;

  task automatic clear_mon();
    n_herr = 0; n_verr = 0; n_fs = 0; fs_bad = 0; trk_bad = 0;
    first_herr = -1; first_verr = -1; lock_rise = -1; lock_fall = -1;
    last_fs = -1; n_vs = 0;
    for (int i = 0; i < 8; i++) vs_cyc[i] = -1;
  endtask

  task automatic src_advance();
    if (s_h >= line_len - 1) begin
      s_h = 0;
      line_len = H_T;
      if (s_v >= frame_len - 1) begin
        s_v = 0;
        frame_len = V_T;
      end else s_v++;
    end else s_h++;
    hsync = (s_h >= HS) && (s_h < HS + 4) && (hs_block == 0);
    if (hs_block > 0) hs_block--;
    vsync = (s_v >= VS) && (s_v < VS + 2);
  endtask

  // One clock: observe what the DUT made of the inputs it just sampled, then move the source on.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    samp_hs_rise = hsync & ~hs_prev;
    if (vsync && !vs_prev) begin
      if (n_vs < 8) vs_cyc[n_vs] = cyc;
      n_vs++;
    end
    hs_prev = hsync;
    vs_prev = vsync;
    samp_v  = s_v;
    if (h_err) begin n_herr++; if (first_herr < 0) first_herr = cyc; end
    if (v_err) begin n_verr++; if (first_verr < 0) first_verr = cyc; end
    if (locked && !locked_prev && lock_rise < 0) lock_rise = cyc;
    if (!locked && locked_prev && lock_fall < 0) lock_fall = cyc;
    locked_prev = locked;
    if (frame_start) begin
      n_fs++;
      if (int'(rx_hcount) != 0 || int'(rx_vcount) != 0) fs_bad++;
      if (last_fs >= 0 && cyc - last_fs != FRAME) fs_bad++;
      last_fs = cyc;
    end
    if (track_en && locked && (int'(rx_hcount) != s_h || int'(rx_vcount) != s_v)) trk_bad++;
    src_advance();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_locked_at(input int h, input int v, input string name);
    int n = 0;
    while (!(s_h == h && s_v == v && locked) && n < 3 * FRAME) begin tick(); n++; end
    vectors++;
    if (!(s_h == h && s_v == v && locked)) begin
      miscompares++; $display("FAIL %s_wait locked=%b pos=%0d,%0d want locked at %0d,%0d", name, locked, s_h, s_v, h, v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    vectors += 7;
    if (rx_hcount !== '0) begin miscompares++; $display("FAIL reset_rx_hcount got %0d want 0", rx_hcount); end
    if (rx_vcount !== '0) begin miscompares++; $display("FAIL reset_rx_vcount got %0d want 0", rx_vcount); end
    if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked got %b want 0", locked); end
    if (frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
    if (h_err !== 1'b0) begin miscompares++; $display("FAIL reset_h_err got %b want 0", h_err); end
    if (v_err !== 1'b0) begin miscompares++; $display("FAIL reset_v_err got %b want 0", v_err); end
    if (err_count !== 8'd0) begin miscompares++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    tick();
    s_h = 0; s_v = 0; line_len = H_T; frame_len = V_T; hs_block = 0;
    hsync = 1'b0; vsync = 1'b0; hs_prev = 1'b0; vs_prev = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_clean_lock();
    clear_mon();
    track_en = 1'b1;
    run(4 * FRAME + 20);
    vectors += 7;
    if (n_vs < 3 || lock_rise != vs_cyc[2] + 1) begin
      miscompares++; $display("FAIL clean_lock_time got %0d want %0d", lock_rise, vs_cyc[2] + 1);
    end
    if (locked !== 1'b1) begin miscompares++; $display("FAIL clean_locked got %b want 1", locked); end
    if (n_herr != 0) begin miscompares++; $display("FAIL clean_h_err got %0d pulses want 0", n_herr); end
    if (n_verr != 0) begin miscompares++; $display("FAIL clean_v_err got %0d pulses want 0", n_verr); end
    if (err_count !== 8'd0) begin miscompares++; $display("FAIL clean_err_count got %0d want 0", err_count); end
    if (trk_bad != 0) begin miscompares++; $display("FAIL clean_tracking got %0d bad cycles want 0", trk_bad); end
    if (lock_fall != -1) begin miscompares++; $display("FAIL clean_lock_drop got cycle %0d want none", lock_fall); end
  endtask

  task automatic test_frame_start();
    clear_mon();
    track_en = 1'b1;
    run(4 * FRAME);
    vectors += 3;
    if (n_fs != 4) begin miscompares++; $display("FAIL fs_count got %0d want 4", n_fs); end
    if (fs_bad != 0) begin miscompares++; $display("FAIL fs_position_spacing got %0d bad want 0", fs_bad); end
    if (trk_bad != 0) begin miscompares++; $display("FAIL fs_tracking got %0d bad cycles want 0", trk_bad); end
  endtask

  task automatic test_long_line();
    int t0;
    track_en = 1'b0;
    wait_locked_at(5, 1, "long_line");
    t0 = cyc;
    clear_mon();
    line_len = H_T + 1;
    run(5 * FRAME);
    vectors += 6;
    if (first_herr != t0 + 69) begin miscompares++; $display("FAIL long_herr_time got %0d want %0d", first_herr, t0 + 69); end
    if (n_herr != 1) begin miscompares++; $display("FAIL long_herr_count got %0d want 1", n_herr); end
    if (lock_fall != t0 + 70) begin miscompares++; $display("FAIL long_lock_fall got %0d want %0d", lock_fall, t0 + 70); end
    if (n_verr != 0) begin miscompares++; $display("FAIL long_v_err got %0d want 0", n_verr); end
    if (err_count !== 8'd1) begin miscompares++; $display("FAIL long_err_count got %0d want 1", err_count); end
    if (n_vs < 3 || lock_rise != vs_cyc[2] + 1) begin
      miscompares++; $display("FAIL long_relock_time got %0d want %0d", lock_rise, vs_cyc[2] + 1);
    end
  endtask

  task automatic test_reset_midlock();
    wait_locked_at(5, 1, "midlock");
    rst = 1'b0;
    tick();
    vectors += 7;
    if (rx_hcount !== '0) begin miscompares++; $display("FAIL midrst_rx_hcount got %0d want 0", rx_hcount); end
    if (rx_vcount !== '0) begin miscompares++; $display("FAIL midrst_rx_vcount got %0d want 0", rx_vcount); end
    if (locked !== 1'b0) begin miscompares++; $display("FAIL midrst_locked got %b want 0", locked); end
    if (frame_start !== 1'b0) begin miscompares++; $display("FAIL midrst_frame_start got %b want 0", frame_start); end
    if (h_err !== 1'b0) begin miscompares++; $display("FAIL midrst_h_err got %b want 0", h_err); end
    if (v_err !== 1'b0) begin miscompares++; $display("FAIL midrst_v_err got %b want 0", v_err); end
    if (err_count !== 8'd0) begin miscompares++; $display("FAIL midrst_err_count got %0d want 0", err_count); end
    rst = 1'b1;
    clear_mon();
    track_en = 1'b1;
    run(4 * FRAME);
    vectors += 4;
    if (n_vs < 3 || lock_rise != vs_cyc[2] + 1) begin
      miscompares++; $display("FAIL midrst_relock_time got %0d want %0d", lock_rise, vs_cyc[2] + 1);
    end
    if (n_herr + n_verr != 0) begin miscompares++; $display("FAIL midrst_errors got %0d want 0", n_herr + n_verr); end
    if (err_count !== 8'd0) begin miscompares++; $display("FAIL midrst_err_count_after got %0d want 0", err_count); end
    if (trk_bad != 0) begin miscompares++; $display("FAIL midrst_tracking got %0d bad cycles want 0", trk_bad); end
  endtask

  task automatic test_short_frame();
    int t0;
    track_en = 1'b0;
    wait_locked_at(5, 1, "short_frame");
    t0 = cyc;
    clear_mon();
    frame_len = V_T - 1;
    run(3 * FRAME);
    vectors += 6;
    if (first_verr != t0 + 596) begin miscompares++; $display("FAIL short_verr_time got %0d want %0d", first_verr, t0 + 596); end
    if (n_verr != 1) begin miscompares++; $display("FAIL short_verr_count got %0d want 1", n_verr); end
    if (n_herr != 0) begin miscompares++; $display("FAIL short_h_err got %0d want 0", n_herr); end
    if (lock_fall != t0 + 597) begin miscompares++; $display("FAIL short_lock_fall got %0d want %0d", lock_fall, t0 + 597); end
    if (err_count !== 8'd1) begin miscompares++; $display("FAIL short_err_count got %0d want 1", err_count); end
    if (locked !== 1'b0) begin miscompares++; $display("FAIL short_locked got %b want 0", locked); end
  endtask

  task automatic test_hsync_stuck();
    int r;
    int n = 0;
    while (!(samp_hs_rise && samp_v == 2 && locked) && n < 4 * FRAME) begin tick(); n++; end
    vectors++;
    if (!(samp_hs_rise && samp_v == 2 && locked)) begin
      miscompares++; $display("FAIL stuck_wait locked=%b want relock before stuck test", locked);
    end
    r = cyc;
    hs_block = 100;
    clear_mon();
    run(200);
    vectors += 6;
    if (first_herr != r + 2 * H_T - 1) begin miscompares++; $display("FAIL stuck_herr_time got %0d want %0d", first_herr, r + 2 * H_T - 1); end
    if (n_herr != 1) begin miscompares++; $display("FAIL stuck_herr_count got %0d want 1", n_herr); end
    if (lock_fall != r + 2 * H_T) begin miscompares++; $display("FAIL stuck_lock_fall got %0d want %0d", lock_fall, r + 2 * H_T); end
    if (locked !== 1'b0) begin miscompares++; $display("FAIL stuck_locked got %b want 0", locked); end
    if (n_verr != 0) begin miscompares++; $display("FAIL stuck_v_err got %0d want 0", n_verr); end
    if (err_count !== 8'd2) begin miscompares++; $display("FAIL stuck_err_count got %0d want 2", err_count); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_clean_lock();
    test_frame_start();
    test_long_line();
    test_reset_midlock();
    test_short_frame();
    test_hsync_stuck();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receive-side counterpart of vga_timing: consumes only hsync/vsync (active-high) and reconstructs the pixel position as rx_hcount/rx_vcount.
- Checks line and frame periods against the configured mode and reports lock and timing errors.
- Sits at the display/monitor end of the VGA path, or in self-check benches, to prove the generated timing is consistent.

Parameters:
H_TOTAL, 1056, clocks per line (800x600@60, 40 MHz)
V_TOTAL, 628, lines per frame
HSYNC_START, 840, hcount at which hsync rises
VSYNC_START, 601, vcount at which vsync rises
LOCK_FRAMES, 2, consecutive clean frames needed before lock
CNT_W, 11, width of all position/period counters

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-low reset
hsync  in  1  horizontal sync from the timing source, active-high
vsync  in  1  vertical sync from the timing source, active-high
rx_hcount  out  CNT_W  recovered horizontal position
rx_vcount  out  CNT_W  recovered vertical position
locked  out  1  high while timing is verified
frame_start  out  1  1-cycle pulse when rx_hcount==0 and rx_vcount==0 while locked
h_err  out  1  1-cycle pulse on a bad line period or hsync timeout
v_err  out  1  1-cycle pulse on a bad frame length
err_count  out  8  saturating count of h_err and v_err events

Behaviour:
- Reset: rst low at a clk edge clears all registers.
  - All outputs 0, state SEARCH, sync history 0, period counters 0, h_seen=0.
  - Reset has priority over any event in the same cycle.
- Edge detection: hs_rise = hsync & ~hsync_q; vs_rise = vsync & ~vsync_q. hsync_q and vsync_q are registered copies.
- Recovered position is registered with 1-cycle latency. When locked, rx_hcount/rx_vcount at cycle t equal the source hcount/vcount at t-1.
- rx_hcount update:
  - hs_rise: load HSYNC_START.
  - else at H_TOTAL-1: wrap to 0.
  - else: +1.
- rx_vcount update:
  - vs_rise: load VSYNC_START. This wins over the line increment in the same cycle.
  - else when rx_hcount wraps: +1, wrapping V_TOTAL-1 -> 0.
- Line period check:
  - h_period counts clocks since the last hs_rise. It saturates at 2*H_TOTAL and is reset to 1 on hs_rise.
  - On hs_rise with h_seen=1, the line is good iff h_period==H_TOTAL.
  - The first hs_rise after reset or SEARCH entry only sets h_seen; it is not checked.
- Frame check: v_lines counts hs_rise events between vs_rise events. On vs_rise in VERIFY/LOCKED, the frame is good iff v_lines==V_TOTAL; v_lines is then reset to 0.
- hsync timeout: h_period reaching 2*H_TOTAL counts as a bad line.
- FSM:
  - SEARCH: wait for vs_rise -> VERIFY, with good_frames=0 and v_lines=0.
  - VERIFY:
    - Any bad line -> h_err, go to SEARCH.
    - Bad frame -> v_err, go to SEARCH.
    - Good vs_rise -> good_frames+1. When good_frames reaches LOCK_FRAMES -> LOCKED, and locked rises on the next cycle.
  - LOCKED:
    - Bad line -> h_err, go to SEARCH.
    - Bad frame -> v_err, go to SEARCH.
    - locked falls the cycle after the error pulse.
- Simultaneous bad line and bad frame: pulse both, err_count +2 (saturating at 255), go to SEARCH.
- Errors in SEARCH are not flagged. Only VERIFY and LOCKED raise h_err/v_err.
- rx_hcount/rx_vcount keep free-running in every state. They are only guaranteed correct while locked.
- frame_start is gated by locked.

Test Plan:
- Clean source: drive from vga_timing for 4 frames after reset release.
  - locked rises 1 clk after the 3rd vs_rise (1st arms VERIFY, then 2 good frames).
  - No h_err/v_err; err_count=0.
  - Once locked, rx_hcount==hcount(t-1) and rx_vcount==vcount(t-1) every cycle.
- Long line: while locked, stretch one line to 1057 clocks.
  - h_err pulses exactly once, at the late hs_rise; locked falls next cycle; err_count=1.
  - Relock occurs after 3 further clean vsync edges.
- Short frame: while locked, drop one line so the frame is 627 lines.
  - v_err pulses at the next vs_rise; h_err stays 0 (line lengths are still 1056); err_count=1; locked drops.
- hsync stuck low: while locked, hold hsync=0 for 2112 clocks.
  - h_err pulses when h_period reaches 2112; state SEARCH; locked=0.
- Reset mid-lock: assert rst=0 for one cycle while locked.
  - Next cycle all outputs are 0 and err_count=0.
  - After release, locking is reacquired exactly as in the clean-source case.
- frame_start: over 4 locked frames exactly 4 pulses, each coinciding with rx_hcount==0 and rx_vcount==0, spaced 1056*628=663168 clocks apart.
